// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - uart_state_e : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   - DEF_CLK_FREQ / DEF_BAUD : default system clock and line rate
//   - baud_mcnt()  : baud counter terminal value for a clock/baud pair
//                    (one bit period = baud_mcnt()+1 cycles)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 9_600;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic int unsigned baud_mcnt(input int unsigned clk_freq,
                                              input int unsigned baud);
        return (clk_freq / baud) - 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// uart_tx_if
// Producer-side bundle of the UART transmitter.
//   tx_data  [7:0] byte to send
//   tx_valid       producer has a byte
//   tx_ready       transmitter holding register is empty
//   tx_busy        frame in progress (START through last STOP)
//   tx_done        one-cycle pulse during the last cycle of each frame
//   uart_tx        serial line, idles high
//
// Handshake: a byte transfers on every rising clock edge where
// tx_valid && tx_ready. tx_ready never depends on tx_valid; the producer
// holds tx_data stable while tx_valid is high and not yet accepted.
// ----------------------------------------------------------------------------
interface uart_tx_if;
    import uart_pkg::*;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       uart_tx;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  uart_tx
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output uart_tx
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// ----------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter. Counts 0..MCNT_BAUD while enabled and wraps; held at 0
// while cleared. tick_o is high during the last cycle of each bit period.
//   clk     system clock
//   rst     asynchronous active-high reset
//   en_i    count enable
//   clr_i   synchronous clear to 0 (wins over en_i)
//   tick_o  counter at terminal value and enabled
// ----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int unsigned MCNT_BAUD = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    import uart_pkg::*;

    localparam int unsigned W = (MCNT_BAUD > 0) ? $clog2(MCNT_BAUD + 1) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_top;

    assign at_top = (cnt_q == W'(MCNT_BAUD));
    assign tick_o = en_i && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// Byte-wide UART transmitter, LSB first, 8 data bits, optional parity,
// 1 or 2 stop bits. One-entry holding register lets the producer pre-load
// the next byte while a frame is on the line; frames then run back-to-back.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset (aborts any frame, drops both
//            shift and holding contents)
//   bus      uart_tx_if.slave: tx_data/tx_valid in, tx_ready/tx_busy/
//            tx_done/uart_tx out
//   state_o  current FSM state (debug)
// ----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned MCNT_BAUD  = baud_mcnt(CLK_FREQ, BAUD),
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    bus,
    output uart_state_e state_o
);

    uart_state_e state_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        stop_idx_q;
    logic        par_q;
    logic        line_q;
    logic        busy_q;

    logic        tick;
    logic        accept;
    logic        last_stop;

    uart_baud_cnt #(
        .MCNT_BAUD (MCNT_BAUD)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    // tx_ready comes only from the holding flag, so accept and drain can never
    // happen on the same edge: drain needs hold_full_q=1, accept needs it 0.
    assign accept    = bus.tx_valid && !hold_full_q;
    assign last_stop = (STOP_BITS >= 2) ? stop_idx_q : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            par_q       <= 1'b0;
            line_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            if (accept) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    if (hold_full_q) begin
                        state_q     <= START;
                        shift_q     <= hold_q;
                        par_q       <= (^hold_q) ^ (PARITY_ODD != 0);
                        hold_full_q <= 1'b0;
                        line_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= 3'd0;
                        line_q    <= shift_q[0];
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                line_q  <= par_q;
                            end else begin
                                state_q    <= STOP;
                                stop_idx_q <= 1'b0;
                                line_q     <= 1'b1;
                            end
                        end else begin
                            // Next bit is shift_q[1]; shift so it lands in [0].
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            line_q    <= shift_q[1];
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        state_q    <= STOP;
                        stop_idx_q <= 1'b0;
                        line_q     <= 1'b1;
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (last_stop) begin
                            if (hold_full_q) begin
                                // Pre-loaded byte: straight into START, no idle gap.
                                state_q     <= START;
                                shift_q     <= hold_q;
                                par_q       <= (^hold_q) ^ (PARITY_ODD != 0);
                                hold_full_q <= 1'b0;
                                line_q      <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                line_q  <= 1'b1;
                            end
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

    // tx_done is a decode of registered state and counter only, so it marks the
    // final stop cycle itself and sits directly before the next frame's START.
    assign bus.tx_done  = (state_q == STOP) && tick && last_stop;
    assign bus.tx_ready = !hold_full_q;
    assign bus.tx_busy  = busy_q;
    assign bus.uart_tx  = line_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
// Four transmitters at 10 cycles/bit:
//   0: no parity, 1 stop   1: even parity   2: odd parity   3: 2 stop bits
// ----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  data_v  [4];
    logic        valid_v [4];
    logic        line_w  [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic        ready_w [4];
    uart_state_e state_w [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_if bus ();

        assign bus.tx_data  = data_v[g];
        assign bus.tx_valid = valid_v[g];
        assign line_w[g]    = bus.uart_tx;
        assign busy_w[g]    = bus.tx_busy;
        assign done_w[g]    = bus.tx_done;
        assign ready_w[g]   = bus.tx_ready;

        uart_tx #(
            .CLK_FREQ   (1_000_000),
            .BAUD       (100_000),
            .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD ((g == 2) ? 1 : 0),
            .STOP_BITS  ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus),
            .state_o (state_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer a byte; returns 1 time unit after the accepting edge.
    task automatic send_byte(input int k, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        data_v[k]  = b;
        valid_v[k] = 1'b1;
        while (!ready_w[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_wait_d%0d", k), 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
    endtask

    // Accept from idle, then the cycle between accept and START still idles.
    task automatic start_frame(input int k, input logic [7:0] b, input string tag);
        send_byte(k, b);
        @(negedge clk);
        check({tag, "_c0_line"}, 32'(line_w[k]), 32'd1);
        check({tag, "_c0_busy"}, 32'(busy_w[k]), 32'd0);
    endtask

    // Checks every cycle of one frame, cycle 1 = first START cycle.
    task automatic check_frame(input int k, input logic [7:0] b, input int pe,
                               input logic par, input int stops, input string tag);
        int   len;
        int   p;
        logic e;
        len = (10 + pe + stops - 1) * 10;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            p = (i - 1) / 10;
            if (p == 0)                  e = 1'b0;
            else if (p <= 8)             e = b[p-1];
            else if (p == 9 && pe != 0)  e = par;
            else                         e = 1'b1;
            check($sformatf("%s_c%0d_line", tag, i), 32'(line_w[k]), 32'(e));
            check($sformatf("%s_c%0d_busy", tag, i), 32'(busy_w[k]), 32'd1);
            check($sformatf("%s_c%0d_done", tag, i), 32'(done_w[k]), 32'(i == len));
            if (i == 1) check($sformatf("%s_c1_ready", tag), 32'(ready_w[k]), 32'd1);
        end
    endtask

    task automatic idle_check(input int k, input string tag);
        @(negedge clk);
        check({tag, "_line"},  32'(line_w[k]),  32'd1);
        check({tag, "_busy"},  32'(busy_w[k]),  32'd0);
        check({tag, "_done"},  32'(done_w[k]),  32'd0);
        check({tag, "_ready"}, 32'(ready_w[k]), 32'd1);
        check({tag, "_state"}, 32'(state_w[k]), 32'(IDLE));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl [4];
        int         hold_err;
        tbl = '{8'h00, 8'hFF, 8'h5A, 8'h81};

        for (int k = 0; k < 4; k++) begin
            data_v[k]  = 8'h00;
            valid_v[k] = 1'b0;
        end

        // Reset values.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) idle_check(k, $sformatf("reset_d%0d", k));
        rst = 1'b0;
        idle_check(0, "after_reset");

        // Single frame 0x55.
        start_frame(0, 8'h55, "f55");
        check_frame(0, 8'h55, 0, 1'b0, 1, "f55");
        idle_check(0, "f55_post");

        // Back-to-back 0xA5 then 0x3C, second offered at cycle 31.
        start_frame(0, 8'hA5, "fa5");
        hold_err = 0;
        fork
            check_frame(0, 8'hA5, 0, 1'b0, 1, "fa5");
            begin
                repeat (30) @(negedge clk);
                send_byte(0, 8'h3C);
                for (int i = 32; i <= 100; i++) begin
                    @(negedge clk);
                    if (ready_w[0] !== 1'b0) hold_err++;
                end
                check("b2b_ready_low_until_start", 32'(hold_err), 32'd0);
            end
        join
        check_frame(0, 8'h3C, 0, 1'b0, 1, "f3c");
        idle_check(0, "f3c_post");

        // Parity even / odd on 0x07 (three ones).
        start_frame(1, 8'h07, "par_even");
        check_frame(1, 8'h07, 1, 1'b1, 1, "par_even");
        idle_check(1, "par_even_post");
        start_frame(2, 8'h07, "par_odd");
        check_frame(2, 8'h07, 1, 1'b0, 1, "par_odd");
        idle_check(2, "par_odd_post");

        // Two stop bits, 0xFF.
        start_frame(3, 8'hFF, "stop2");
        check_frame(3, 8'hFF, 0, 1'b0, 2, "stop2");
        idle_check(3, "stop2_post");

        // Reset during data bit 3 with a byte pre-loaded.
        start_frame(0, 8'h96, "rstf");
        repeat (19) @(negedge clk);
        send_byte(0, 8'h11);
        repeat (22) @(negedge clk);
        check("rst_pre_ready", 32'(ready_w[0]), 32'd0);
        check("rst_pre_busy",  32'(busy_w[0]),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_line",  32'(line_w[0]),  32'd1);
        check("rst_async_busy",  32'(busy_w[0]),  32'd0);
        check("rst_async_ready", 32'(ready_w[0]), 32'd1);
        check("rst_async_done",  32'(done_w[0]),  32'd0);
        for (int i = 0; i < 3; i++) idle_check(0, $sformatf("rst_hold%0d", i));
        rst = 1'b0;
        for (int i = 0; i < 15; i++) idle_check(0, $sformatf("rst_after%0d", i));
        start_frame(0, 8'hC3, "fc3");
        check_frame(0, 8'hC3, 0, 1'b0, 1, "fc3");
        idle_check(0, "fc3_post");

        // Pattern table.
        for (int t = 0; t < 4; t++) begin
            start_frame(0, tbl[t], $sformatf("tbl%0d", t));
            check_frame(0, tbl[t], 0, 1'b0, 1, $sformatf("tbl%0d", t));
            idle_check(0, $sformatf("tbl%0d_post", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
